// File: rtl/alu_arb_pkg.sv
// Shared constants and FSM encoding for the ALU arbiter slice.
package alu_arb_pkg;
  localparam int DW      = 16;
  localparam int CTL_W   = 3;
  localparam int SHIFT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_t;

  localparam logic [CTL_W-1:0] OP_ADD = 3'b000;
  localparam logic [CTL_W-1:0] OP_SUB = 3'b001;
  localparam logic [CTL_W-1:0] OP_AND = 3'b010;
  localparam logic [CTL_W-1:0] OP_OR  = 3'b011;
  localparam logic [CTL_W-1:0] OP_XOR = 3'b100;
  localparam logic [CTL_W-1:0] OP_SHL = 3'b101;
  localparam logic [CTL_W-1:0] OP_SHR = 3'b110;
  localparam logic [CTL_W-1:0] OP_PSB = 3'b111;
endpackage

// File: rtl/alu.sv
// Shared combinational ALU; overflow is signed overflow of add/sub, 0 for other ops.
module alu
  import alu_arb_pkg::*;
#(
  parameter int DW = alu_arb_pkg::DW
) (
  input  logic [DW-1:0]      ALU_DA,
  input  logic [DW-1:0]      ALU_DB,
  input  logic [CTL_W-1:0]   ALU_CTL,
  input  logic [SHIFT_W-1:0] ALU_SHIFT,
  output logic [DW-1:0]      ALU_DC,
  output logic               ALU_OverFlow
);
  always_comb begin
    ALU_DC       = '0;
    ALU_OverFlow = 1'b0;
    case (ALU_CTL)
      OP_ADD: begin
        ALU_DC       = ALU_DA + ALU_DB;
        ALU_OverFlow = (ALU_DA[DW-1] == ALU_DB[DW-1]) && (ALU_DC[DW-1] != ALU_DA[DW-1]);
      end
      OP_SUB: begin
        ALU_DC       = ALU_DA - ALU_DB;
        ALU_OverFlow = (ALU_DA[DW-1] != ALU_DB[DW-1]) && (ALU_DC[DW-1] != ALU_DA[DW-1]);
      end
      OP_AND:  ALU_DC = ALU_DA & ALU_DB;
      OP_OR:   ALU_DC = ALU_DA | ALU_DB;
      OP_XOR:  ALU_DC = ALU_DA ^ ALU_DB;
      OP_SHL:  ALU_DC = ALU_DA << ALU_SHIFT;
      OP_SHR:  ALU_DC = ALU_DA >> ALU_SHIFT;
      default: ALU_DC = ALU_DB;
    endcase
  end
endmodule

// File: rtl/alu_rr_picker.sv
// Round-robin picker: search begins one past rr_ptr, first valid requester wins.
module alu_rr_picker #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NREQ requesters, registered result.
// Optional perf counters (PERF_GRANTS/PERF_OVF) are built when ALU_ARB_PERF_EN is defined.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DW    = alu_arb_pkg::DW,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         REQ_VALID,
  output logic [NREQ-1:0]         REQ_READY,
  input  logic [NREQ*DW-1:0]      REQ_DA,
  input  logic [NREQ*DW-1:0]      REQ_DB,
  input  logic [NREQ*CTL_W-1:0]   REQ_CTL,
  input  logic [NREQ*SHIFT_W-1:0] REQ_SHIFT,
  output logic [NREQ-1:0]         RSP_VALID,
  input  logic [NREQ-1:0]         RSP_READY,
  output logic [DW-1:0]           RSP_DC,
  output logic                    RSP_OVF,
`ifdef ALU_ARB_PERF_EN
  output logic [NREQ*CNT_W-1:0]   PERF_GRANTS,
  output logic [CNT_W-1:0]        PERF_OVF,
`endif
  output logic                    dbg_state
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4 || CNT_W < 1) begin : g_bad_param
    $error("alu_arbiter: NREQ must be 2..4 and CNT_W >= 1");
  end

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     owner_q, rr_ptr_q, win_idx;
  logic [NREQ-1:0]   win_grant;
  logic              win_any;
  logic              fire;
  logic [DW-1:0]     dc_q, alu_da, alu_db, alu_dc;
  logic              ovf_q, alu_ovf;
  logic [CTL_W-1:0]  alu_ctl;
  logic [SHIFT_W-1:0] alu_shift;

  alu_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .valid  (REQ_VALID),
    .rr_ptr (rr_ptr_q),
    .grant  (win_grant),
    .idx    (win_idx),
    .any    (win_any)
  );

  assign alu_da    = REQ_DA[int'(win_idx)*DW +: DW];
  assign alu_db    = REQ_DB[int'(win_idx)*DW +: DW];
  assign alu_ctl   = REQ_CTL[int'(win_idx)*CTL_W +: CTL_W];
  assign alu_shift = REQ_SHIFT[int'(win_idx)*SHIFT_W +: SHIFT_W];

  alu #(.DW(DW)) u_alu (
    .ALU_DA       (alu_da),
    .ALU_DB       (alu_db),
    .ALU_CTL      (alu_ctl),
    .ALU_SHIFT    (alu_shift),
    .ALU_DC       (alu_dc),
    .ALU_OverFlow (alu_ovf)
  );

  // Handshake: a request transfers on a cycle where REQ_VALID[i] && REQ_READY[i];
  // a result transfers where RSP_VALID[owner] && RSP_READY[owner]. A new grant
  // is only issued when the register is empty or its result leaves this cycle.
  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          fire    = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (RSP_READY[owner_q]) begin
          if (win_any) fire = 1'b1;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!rst_n) fire = 1'b0;
  end

  assign REQ_READY = fire ? win_grant : '0;
  assign dbg_state = state_q;

  always_comb begin
    RSP_VALID = '0;
    if (state_q == ST_RESP) RSP_VALID[owner_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      dc_q     <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        owner_q  <= win_idx;
        rr_ptr_q <= win_idx;
        dc_q     <= alu_dc;
        ovf_q    <= alu_ovf;
      end
    end
  end

  assign RSP_DC  = dc_q;
  assign RSP_OVF = ovf_q;

`ifdef ALU_ARB_PERF_EN
  logic [NREQ-1:0][CNT_W-1:0] grants_q;
  logic [CNT_W-1:0]           ovf_cnt_q;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grants_q  <= '0;
      ovf_cnt_q <= '0;
    end else if (fire) begin
      if (grants_q[win_idx] != '1) grants_q[win_idx] <= grants_q[win_idx] + CNT_W'(1);
      if (alu_ovf && ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
    end
  end

  assign PERF_GRANTS = grants_q;
  assign PERF_OVF    = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard.
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int DW   = 16;
`ifdef ALU_ARB_PERF_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int EW = NREQ + DW + 1;

  logic                clk, rst_n;
  logic [NREQ-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*DW-1:0]  req_da, req_db;
  logic [NREQ*3-1:0]   req_ctl;
  logic [NREQ*4-1:0]   req_shift;
  logic [DW-1:0]       rsp_dc;
  logic                rsp_ovf, dbg_state;
`ifdef ALU_ARB_PERF_EN
  logic [NREQ*CNT_W-1:0] perf_grants;
  logic [CNT_W-1:0]      perf_ovf;
`endif

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] t_da  [2][4] = '{'{16'd100, 16'h1234, 16'hFFFF, 16'h4000}, '{16'd500, 16'hF0F0, 16'h0123, 16'hAAAA}};
  logic [15:0] t_db  [2][4] = '{'{16'd23,  16'h1111, 16'h0001, 16'h4000}, '{16'd200, 16'hFF00, 16'h0000, 16'h5555}};
  logic [2:0]  t_ctl [2][4] = '{'{3'd0, 3'd0, 3'd0, 3'd0}, '{3'd1, 3'd2, 3'd5, 3'd4}};
  logic [3:0]  t_sh  [2][4] = '{'{4'd0, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd4, 4'd0}};
  logic [15:0] t_dc  [2][4] = '{'{16'd123, 16'h2345, 16'h0000, 16'h8000}, '{16'd300, 16'hF000, 16'h1230, 16'hFFFF}};
  logic        t_ovf [2][4] = '{'{1'b0, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b0, 1'b0}};

  alu_arbiter #(.NREQ(NREQ), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .REQ_VALID   (req_valid),
    .REQ_READY   (req_ready),
    .REQ_DA      (req_da),
    .REQ_DB      (req_db),
    .REQ_CTL     (req_ctl),
    .REQ_SHIFT   (req_shift),
    .RSP_VALID   (rsp_valid),
    .RSP_READY   (rsp_ready),
    .RSP_DC      (rsp_dc),
    .RSP_OVF     (rsp_ovf),
`ifdef ALU_ARB_PERF_EN
    .PERF_GRANTS (perf_grants),
    .PERF_OVF    (perf_ovf),
`endif
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] mk_exp(input int i, input logic [DW-1:0] dc, input logic ovf);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    return {oh, dc, ovf};
  endfunction

  // Driver tasks
  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1 rst_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [15:0] da, input logic [15:0] db,
                         input logic [2:0] ctl, input logic [3:0] sh);
    req_da[i*DW +: DW]  = da;
    req_db[i*DW +: DW]  = db;
    req_ctl[i*3 +: 3]   = ctl;
    req_shift[i*4 +: 4] = sh;
    req_valid[i]        = 1'b1;
  endtask

  task automatic issue(input int i, input logic [15:0] da, input logic [15:0] db,
                       input logic [2:0] ctl, input logic [3:0] sh,
                       input logic [15:0] edc, input logic eovf);
    bit got;
    got = 1'b0;
    set_req(i, da, db, ctl, sh);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        exp_q.push_back(mk_exp(i, edc, eovf));
      end
    end
    if (!got) begin
      n_checks++;
      $display("FAIL grant_timeout: requester %0d never granted", i);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: compares every result handed to its owner
  always @(negedge clk) begin
    if (rst_n && ((rsp_valid & rsp_ready) != '0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got valid=%b dc=%h ovf=%b with no expected entry",
                 rsp_valid, rsp_dc, rsp_ovf);
      end else begin
        chk("rsp", {rsp_valid, rsp_dc, rsp_ovf}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int a0, a1, w;
    rst_n = 1'b1; req_valid = '0; rsp_ready = '0;
    req_da = '0; req_db = '0; req_ctl = '0; req_shift = '0;
    #2 rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_rsp_dc", rsp_dc, 16'h0000);
    chk("reset_rsp_ovf", rsp_ovf, 1'b0);
    chk("reset_state", dbg_state, 1'b0);
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single add on requester 0
    rsp_ready = 2'b11;
    set_req(0, 16'd51, 16'd59, 3'b000, 4'd0);
    @(negedge clk);
    chk("t1_grant", req_ready, 2'b01);
    exp_q.push_back(mk_exp(0, 16'd110, 1'b0));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_dc", rsp_dc, 16'd110);
    @(negedge clk);
    chk("t1_back_idle", rsp_valid, 2'b00);

    // 2: both requesters busy, strict alternation, one result per cycle
    apply_reset();
    rsp_ready = 2'b11;
    a0 = 0; a1 = 0;
    set_req(0, t_da[0][0], t_db[0][0], t_ctl[0][0], t_sh[0][0]);
    set_req(1, t_da[1][0], t_db[1][0], t_ctl[1][0], t_sh[1][0]);
    for (int c = 0; c < 8; c++) begin
      w = c % 2;
      @(negedge clk);
      chk("t2_grant", req_ready, 2'b01 << w);
      if (c > 0) chk("t2_no_gap", rsp_valid, 2'b01 << (1 - w));
      if (w == 0) exp_q.push_back(mk_exp(0, t_dc[0][a0], t_ovf[0][a0]));
      else        exp_q.push_back(mk_exp(1, t_dc[1][a1], t_ovf[1][a1]));
      @(posedge clk);
      #1;
      if (w == 0) begin
        a0++;
        if (a0 < 4) set_req(0, t_da[0][a0], t_db[0][a0], t_ctl[0][a0], t_sh[0][a0]);
        else req_valid[0] = 1'b0;
      end else begin
        a1++;
        if (a1 < 4) set_req(1, t_da[1][a1], t_db[1][a1], t_ctl[1][a1], t_sh[1][a1]);
        else req_valid[1] = 1'b0;
      end
    end
    drain();

    // 3: signed overflow
    apply_reset();
    rsp_ready = 2'b11;
    issue(0, 16'h7FFF, 16'h0001, 3'b000, 4'd0, 16'h8000, 1'b1);
    drain();
`ifdef ALU_ARB_PERF_EN
    chk("t3_perf_ovf", perf_ovf, 1);
`endif

    // 4: owner backpressure blocks new grants; non-owner RSP_READY ignored
    apply_reset();
    rsp_ready = 2'b10;
    set_req(0, 16'd3, 16'd4, 3'b000, 4'd0);
    @(negedge clk);
    chk("t4_grant0", req_ready, 2'b01);
    exp_q.push_back(mk_exp(0, 16'd7, 1'b0));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    set_req(1, 16'h0100, 16'h0001, 3'b001, 4'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 2'b01);
      chk("t4_hold_dc", rsp_dc, 16'd7);
      chk("t4_no_grant", req_ready, 2'b00);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    @(negedge clk);
    chk("t4_grant1", req_ready, 2'b10);
    exp_q.push_back(mk_exp(1, 16'h00FF, 1'b0));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain();

    // 5: reset while a result is held
    apply_reset();
    set_req(1, 16'h0F0F, 16'h00FF, 3'b011, 4'd0);
    @(negedge clk);
    chk("t5_grant1", req_ready, 2'b10);
    exp_q.push_back(mk_exp(1, 16'h0FFF, 1'b0));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("t5_held_dc", rsp_dc, 16'h0FFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", rsp_valid, 2'b00);
    chk("t5_rst_dc", rsp_dc, 16'h0000);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 2'b11;
    set_req(0, 16'h8000, 16'h0000, 3'b110, 4'd15);
    set_req(1, 16'd2, 16'd2, 3'b000, 4'd0);
    @(negedge clk);
    chk("t5_req0_first", req_ready, 2'b01);
    exp_q.push_back(mk_exp(0, 16'h0001, 1'b0));
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t5_then_req1", req_ready, 2'b10);
    exp_q.push_back(mk_exp(1, 16'd4, 1'b0));
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain();

    // 6: one requester wins back-to-back; counter saturation when enabled
    apply_reset();
    rsp_ready = 2'b11;
    set_req(1, 16'd1, 16'd1, 3'b000, 4'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("t6_b2b_grant", req_ready, 2'b10);
      exp_q.push_back(mk_exp(1, 16'd2, 1'b0));
      @(posedge clk);
    end
    #1 req_valid[1] = 1'b0;
    drain();
`ifdef ALU_ARB_PERF_EN
    chk("t6_perf_grants1", perf_grants[CNT_W +: CNT_W], 4'hF);
    chk("t6_perf_grants0", perf_grants[0 +: CNT_W], 4'h0);
    chk("t6_perf_ovf", perf_ovf, 4'h0);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
